// File: rtl/lfsr_pkg.sv
// lfsr_pkg: command/state encodings and reset defaults for the LFSR sequencer
package lfsr_pkg;
  typedef enum logic [1:0] {LOAD_TAP = 2'b00, LOAD_SEED = 2'b01, RUN = 2'b10, RSVD = 2'b11} cmd_op_e;
  typedef enum logic [2:0] {S_INIT_TAP, S_INIT_SEED, S_IDLE, S_WR_TAP, S_WR_SEED, S_RUN, S_FIN} state_e;
  localparam logic [31:0] DEFAULT_TAP = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: one Fibonacci shift-left step of the LFSR
module lfsr_next #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] st,
  input  logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] nxt
);
  assign nxt = {st[WIDTH-2:0], ^(st & tap)};
endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: command sequencer keeping the LFSR register file in step with shadow tap/state
module lfsr_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter logic [WIDTH-1:0] DEFAULT_TAP = lfsr_pkg::DEFAULT_TAP,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             wr_e,
  output logic             wr_tap,
  output logic             data_src_lfs,
  output logic [WIDTH-1:0] wd,
  output logic             addr_valid,
  output logic [WIDTH-1:0] addr,
  output logic             done,
  output logic             err
);
  import lfsr_pkg::*;
  state_e state;
  cmd_op_e op;
  logic [WIDTH-1:0] tap_q, st_q, nxt;
  logic [CNT_W-1:0] cnt, n;
  logic acc;
  assign op = cmd_op_e'(cmd_op);
  assign n = cmd_data[CNT_W-1:0];
  assign acc = cmd_valid && cmd_ready;
  lfsr_next #(.WIDTH(WIDTH)) u_next (.st(st_q), .tap(tap_q), .nxt(nxt));
  // Outputs are registered on the edge entering a state, so a step is visible in the cycle it belongs to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT_TAP;
      tap_q <= DEFAULT_TAP;
      st_q <= DEFAULT_SEED;
      cnt <= '0;
      cmd_ready <= 1'b0;
      wr_e <= 1'b0;
      wr_tap <= 1'b0;
      data_src_lfs <= 1'b0;
      wd <= '0;
      addr_valid <= 1'b0;
      addr <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      wr_e <= 1'b0;
      addr_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        S_INIT_TAP: begin
          state <= S_INIT_SEED;
          wr_e <= 1'b1;
          wr_tap <= 1'b1;
          data_src_lfs <= 1'b0;
          wd <= DEFAULT_TAP;
        end
        S_INIT_SEED: begin
          state <= S_IDLE;
          wr_e <= 1'b1;
          wr_tap <= 1'b0;
          data_src_lfs <= 1'b0;
          wd <= DEFAULT_SEED;
        end
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (acc) begin
            case (op)
              LOAD_TAP: begin
                tap_q <= cmd_data;
                state <= S_WR_TAP;
                cmd_ready <= 1'b0;
                wr_e <= 1'b1;
                wr_tap <= 1'b1;
                data_src_lfs <= 1'b0;
                wd <= cmd_data;
              end
              LOAD_SEED: begin
                st_q <= cmd_data;
                state <= S_WR_SEED;
                cmd_ready <= 1'b0;
                wr_e <= 1'b1;
                wr_tap <= 1'b0;
                data_src_lfs <= 1'b0;
                wd <= cmd_data;
              end
              RUN: begin
                if (st_q == '0) begin
                  err <= 1'b1;
                end else if (n == '0) begin
                  state <= S_FIN;
                  cmd_ready <= 1'b0;
                  done <= 1'b1;
                end else begin
                  state <= S_RUN;
                  cmd_ready <= 1'b0;
                  cnt <= n - 1'b1;
                  st_q <= nxt;
                  wr_e <= 1'b1;
                  wr_tap <= 1'b0;
                  data_src_lfs <= 1'b1;
                  wd <= nxt;
                  addr_valid <= 1'b1;
                  addr <= nxt;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_WR_TAP, S_WR_SEED, S_FIN: begin
          state <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        S_RUN: begin
          if (abort || cnt == '0) begin
            state <= S_FIN;
            done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            st_q <= nxt;
            wr_e <= 1'b1;
            wr_tap <= 1'b0;
            data_src_lfs <= 1'b1;
            wd <= nxt;
            addr_valid <= 1'b1;
            addr <= nxt;
          end
        end
        default: state <= S_INIT_TAP;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: randomized command stream checked against a behavioural LFSR model
module tb_lfsr_seq_ctrl;
  localparam logic [31:0] DT = 32'h8020_0003;
  localparam logic [31:0] DS = 32'h0000_0001;
  localparam logic [6:0] M = 7'b1001111;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [31:0] cmd_data = '0;
  logic cmd_ready, wr_e, wr_tap, data_src_lfs, addr_valid, done, err;
  logic [31:0] wd, addr;
  logic [6:0] ctl;
  logic [31:0] m_tap, m_st;
  int checks = 0, errors = 0;
  assign ctl = {wr_e, wr_tap, data_src_lfs, addr_valid, done, err, cmd_ready};

  lfsr_seq_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .wr_e(wr_e),
    .wr_tap(wr_tap), .data_src_lfs(data_src_lfs), .wd(wd),
    .addr_valid(addr_valid), .addr(addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] model_next(input logic [31:0] s, input logic [31:0] t);
    int p;
    p = $countones(s & t);
    return (s << 1) | 32'(p % 2);
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] d);
    int w = 0;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ctl, wd, addr} !== '0) begin
      errors++;
      $display("FAIL reset_vals got ctl=%b wd=%h addr=%h exp all 0", ctl, wd, addr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1100000 || wd !== DT) begin
      errors++;
      $display("FAIL init_tap got ctl=%b wd=%h exp ctl=1100000 wd=%h", ctl, wd, DT);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1000000 || wd !== DS) begin
      errors++;
      $display("FAIL init_seed got ctl=%b wd=%h exp ctl=1000000 wd=%h", ctl, wd, DS);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++;
      $display("FAIL init_ready got ctl=%b exp 0000001", ctl);
    end
    m_tap = DT;
    m_st = DS;
  endtask

  task automatic test_load(input bit is_tap, input logic [31:0] d);
    abort = 1'($urandom_range(0, 1));
    issue(is_tap ? 2'b00 : 2'b01, d);
    checks++;
    if (ctl !== (is_tap ? 7'b1100000 : 7'b1000000) || wd !== d) begin
      errors++;
      $display("FAIL load_%s got ctl=%b wd=%h exp wd=%h", is_tap ? "tap" : "seed", ctl, wd, d);
    end
    if (is_tap) m_tap = d;
    else m_st = d;
    @(negedge clk);
    checks++;
    if ((ctl & M) !== 7'b0000001) begin
      errors++;
      $display("FAIL load_after got ctl=%b exp ready only", ctl & M);
    end
  endtask

  task automatic test_run(input int n, input int a);
    int steps;
    abort = 1'($urandom_range(0, 1));
    issue(2'b10, 32'(n));
    if (m_st == '0) begin
      checks++;
      if ((ctl & M) !== 7'b0000011) begin
        errors++;
        $display("FAIL lockup_err got ctl=%b exp 0000011", ctl & M);
      end
      @(negedge clk);
      checks++;
      if ((ctl & M) !== 7'b0000001) begin
        errors++;
        $display("FAIL lockup_after got ctl=%b exp 0000001", ctl & M);
      end
      return;
    end
    steps = (a > 0 && a < n) ? a : n;
    for (int k = 1; k <= steps; k++) begin
      m_st = model_next(m_st, m_tap);
      checks++;
      if (ctl !== 7'b1011000 || wd !== m_st || addr !== m_st) begin
        errors++;
        $display("FAIL run_step%0d got ctl=%b wd=%h addr=%h exp ctl=1011000 val=%h", k, ctl, wd, addr, m_st);
      end
      if (k == a) abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    checks++;
    if ((ctl & M) !== 7'b0000100) begin
      errors++;
      $display("FAIL run_done n=%0d got ctl=%b exp 0000100", n, ctl & M);
    end
    @(negedge clk);
    checks++;
    if ((ctl & M) !== 7'b0000001) begin
      errors++;
      $display("FAIL run_after n=%0d got ctl=%b exp 0000001", n, ctl & M);
    end
  endtask

  task automatic test_basic();
    test_load(1'b1, 32'h1);
    test_load(1'b0, 32'h1);
    test_run(3, 0);
    checks++;
    if (m_st !== 32'hF || wd !== 32'hF) begin
      errors++;
      $display("FAIL basic_final got wd=%h exp 0000000f", wd);
    end
    test_run(0, 0);
  endtask

  task automatic test_lockup();
    test_load(1'b0, 32'h0);
    test_run(5, 0);
    test_load(1'b0, 32'hACE1);
  endtask

  task automatic test_reserved();
    issue(2'b11, $urandom);
    checks++;
    if ((ctl & M) !== 7'b0000011) begin
      errors++;
      $display("FAIL reserved_err got ctl=%b exp 0000011", ctl & M);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    test_load(1'b1, DT);
    test_load(1'b0, $urandom | 32'h1);
    test_run(10, 3);
    test_run(1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1: test_load(1'b1, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
        2, 3: test_load(1'b0, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
        4: test_reserved();
        default: test_run($urandom_range(0, 12), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0);
      endcase
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    d = $urandom | 32'h1;
    test_load(1'b0, $urandom | 32'h1);
    issue(2'b10, 32'd8);
    @(negedge clk);
    #2;
    reset = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_data = d;
    #1;
    checks++;
    if ({ctl, wd, addr} !== '0) begin
      errors++;
      $display("FAIL midrun_clear got ctl=%b wd=%h addr=%h exp all 0", ctl, wd, addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1100000 || wd !== DT) begin
      errors++;
      $display("FAIL midrun_tap got ctl=%b wd=%h exp wd=%h", ctl, wd, DT);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1000000 || wd !== DS) begin
      errors++;
      $display("FAIL midrun_seed got ctl=%b wd=%h exp wd=%h", ctl, wd, DS);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++;
      $display("FAIL midrun_ready got ctl=%b exp 0000001", ctl);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (ctl !== 7'b1100000 || wd !== d) begin
      errors++;
      $display("FAIL midrun_held_cmd got ctl=%b wd=%h exp wd=%h", ctl, wd, d);
    end
    m_tap = d;
    m_st = DS;
    @(negedge clk);
    test_run(4, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lockup();
    test_reserved();
    test_abort();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
